// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - dino geometry constants, state encoding and saturating subtract helper
package dino_pkg;

  localparam logic [8:0] GROUND_Y    = 9'd200;
  localparam logic [8:0] DINO_HEIGHT = 9'd28;
  localparam logic [8:0] DINO_X      = 9'd40;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } dino_state_e;

  // p - d, clamped so the sprite top never leaves the screen
  function automatic logic [8:0] sat_sub(input logic [8:0] p, input logic [4:0] d,
                                         input logic [8:0] lo);
    logic [9:0] floor_sum;
    floor_sum = {1'b0, lo} + {5'd0, d};
    if ({1'b0, p} < floor_sum) return lo;
    return p - {4'd0, d};
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge pulse from an already synchronised level
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/dino_jump_ctrl.sv
// rtl/dino_jump_ctrl.sv - per-frame dino jump physics; DINO_FAST_FALL_EN enables duck-to-fall
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter logic [4:0] JUMP_V     = 5'd10,
  parameter logic [4:0] GRAVITY    = 5'd1,
  parameter logic [4:0] MAX_FALL_V = 5'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       jump_btn,
  input  logic       freeze,
  input  logic       duck_btn,
  output logic [8:0] pos,
  output logic       airborne,
  output logic       landed
);

  dino_state_e state, state_n;
  logic [4:0]  vel, vel_n, nv;
  logic [8:0]  pos_n;
  logic        jump_pending, pending_n, landed_n;
  logic        jump_edge;
  logic        rise_cut;
  logic [5:0]  fall_g, nv_sum;
  logic [9:0]  land_sum;

  edge_detect u_jump_edge (
    .clk   (clk),
    .rst   (rst),
    .level (jump_btn),
    .pulse (jump_edge)
  );

`ifdef DINO_FAST_FALL_EN
  assign rise_cut = duck_btn;
  assign fall_g   = {GRAVITY, 1'b0};
`else
  logic unused_duck;
  assign unused_duck = duck_btn;
  assign rise_cut    = 1'b0;
  assign fall_g      = {1'b0, GRAVITY};
`endif

  // Fall sum is 10 bits wide so pos + nv cannot wrap past 511
  assign nv_sum   = {1'b0, vel} + fall_g;
  assign nv       = (nv_sum > {1'b0, MAX_FALL_V}) ? MAX_FALL_V : nv_sum[4:0];
  assign land_sum = {1'b0, pos} + {5'd0, nv};

  always_comb begin
    state_n   = state;
    vel_n     = vel;
    pos_n     = pos;
    pending_n = jump_pending;
    landed_n  = 1'b0;
    if (freeze) begin
      pending_n = 1'b0;
    end else begin
      case (state)
        GROUND: begin
          if (jump_edge) pending_n = 1'b1;
          if (frame_tick && (jump_pending || jump_edge)) begin
            vel_n     = JUMP_V - GRAVITY;
            pos_n     = sat_sub(pos, JUMP_V, DINO_HEIGHT);
            pending_n = 1'b0;
            state_n   = RISE;
          end
        end
        RISE: begin
          if (frame_tick) begin
            pos_n = sat_sub(pos, vel, DINO_HEIGHT);
            if (rise_cut || vel <= GRAVITY) begin
              vel_n   = 5'd0;
              state_n = FALL;
            end else begin
              vel_n = vel - GRAVITY;
            end
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (land_sum >= {1'b0, GROUND_Y}) begin
              pos_n    = GROUND_Y;
              vel_n    = 5'd0;
              landed_n = 1'b1;
              state_n  = GROUND;
            end else begin
              pos_n = land_sum[8:0];
              vel_n = nv;
            end
          end
        end
        default: state_n = GROUND;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= GROUND;
      vel          <= 5'd0;
      pos          <= GROUND_Y;
      jump_pending <= 1'b0;
      airborne     <= 1'b0;
      landed       <= 1'b0;
    end else begin
      state        <= state_n;
      vel          <= vel_n;
      pos          <= pos_n;
      jump_pending <= pending_n;
      airborne     <= (state_n != GROUND);
      landed       <= landed_n;
    end
  end

endmodule
